dff_rr_arbiter: RTL

DFF_RR_ARBITER -- requirements
Module: dff_rr_arbiter

---
 rtl/dff_rr_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dff_rr_arbiter.sv
// dff_rr_arbiter: round-robin arbiter that lets one of N_REQ requesters at a
// time write a shared DW-bit register. A grant lasts for one write, or for up
// to MAX_HOLD consecutive writes while the owner keeps lock asserted. A grant
// is never preempted. Every grant is followed by one idle cycle.
module dff_rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [N_REQ*DW-1:0]      data,
    output logic [N_REQ-1:0]         gnt,
    output logic [DW-1:0]            q,
    output logic                     q_valid,
    output logic [$clog2(N_REQ)-1:0] q_src,
    output logic                     busy
);

    localparam int SW  = $clog2(N_REQ);
    // The hold counter only has to reach MAX_HOLD-1, so it saturates by
    // construction and never wraps.
    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    localparam logic [SW-1:0]    PTR_RST   = SW'(N_REQ - 1);
    localparam logic [HCW-1:0]   HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Registered state
    state_t           state_r;
    logic [N_REQ-1:0] gnt_r;
    logic [SW-1:0]    ptr_r;
    logic [HCW-1:0]   hold_r;
    logic [DW-1:0]    q_r;
    logic             q_valid_r;
    logic [SW-1:0]    q_src_r;
    logic             busy_r;

    // Next-state values
    state_t           state_s;
    logic [N_REQ-1:0] gnt_s;
    logic [SW-1:0]    ptr_s;
    logic [HCW-1:0]   hold_s;
    logic [DW-1:0]    q_s;
    logic             q_valid_s;
    logic [SW-1:0]    q_src_s;
    logic             busy_s;

    // Arbitration helpers
    logic [SW-1:0]    win_s;
    logic             found_s;
    logic [SW-1:0]    idx_s;
    logic [DW-1:0]    data_arr_s [N_REQ];

    // Slice the flat data bus into one word per requester.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign data_arr_s[gi] = data[gi*DW +: DW];
    end

    // Rotating priority search: first set req strictly after ptr, wrapping.
    always_comb begin
        win_s   = PTR_RST;
        found_s = 1'b0;
        idx_s   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx_s = SW'((int'(ptr_r) + off) % N_REQ);
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // FSM next-state and datapath decisions.
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        ptr_s     = ptr_r;
        hold_s    = hold_r;
        q_s       = q_r;
        q_valid_s = 1'b0;
        q_src_s   = q_src_r;

        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s = ST_GRANT;
                    gnt_s   = ONE_HOT0 << win_s;
                    ptr_s   = win_s;
                    hold_s  = '0;
                end else begin
                    gnt_s   = '0;
                end
            end
            ST_GRANT: begin
                // Only the owner's req/lock are looked at; others wait.
                if (req[ptr_r]) begin
                    q_s       = data_arr_s[ptr_r];
                    q_src_s   = ptr_r;
                    q_valid_s = 1'b1;
                    if (lock[ptr_r] && (hold_r < HOLD_LAST)) begin
                        hold_s = hold_r + 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        gnt_s   = '0;
                        hold_s  = '0;
                    end
                end else begin
                    // Owner withdrew: release without writing.
                    state_s = ST_IDLE;
                    gnt_s   = '0;
                    hold_s  = '0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = '0;
                hold_s  = '0;
            end
        endcase

        busy_s = (state_s == ST_GRANT);
    end

    // State and output registers; reset restarts arbitration at requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            gnt_r     <= '0;
            ptr_r     <= PTR_RST;
            hold_r    <= '0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
            q_src_r   <= '0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            gnt_r     <= gnt_s;
            ptr_r     <= ptr_s;
            hold_r    <= hold_s;
            q_r       <= q_s;
            q_valid_r <= q_valid_s;
            q_src_r   <= q_src_s;
            busy_r    <= busy_s;
        end
    end

    assign gnt     = gnt_r;
    assign q       = q_r;
    assign q_valid = q_valid_r;
    assign q_src   = q_src_r;
    assign busy    = busy_r;

endmodule
